// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline control for the 5-stage RISC-V core. Produces the enable and
//   synchronous-clear strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC enable. It resolves data-memory wait states,
//   multi-cycle mul/div occupancy of EX, taken-branch flushes and load-use
//   stalls. It also keeps a saturating count of cycles in which the PC was held.
//
// Parameters
//   MD_CYCLES  cycles a mul/div op occupies EX (2..255)
//   REG_W      register-index width
//   CNT_W      stall-cycle counter width
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   r                    asynchronous active-high reset
//   id_rs1, id_rs2       source registers of the instruction in ID
//   id_rs1_used/_rs2_used  ID instruction actually reads rs1 / rs2
//   ex_rd                destination register of the instruction in EX
//   ex_mem_read          EX instruction is a load
//   ex_branch_taken      EX resolved a taken branch or jump
//   ex_md_start          one-cycle pulse: a mul/div op entered EX
//   mem_busy             data memory not ready, MEM must hold
//   pc_en                PC register enable
//   ifid_en/ifid_r ... memwb_en/memwb_r  pipeline register enable / clear
//   md_busy              a mul/div op is still occupying EX
//   stall_cycles         saturating count of cycles with pc_en low
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             r,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_r,
  output logic             idex_en,
  output logic             idex_r,
  output logic             exmem_en,
  output logic             exmem_r,
  output logic             memwb_en,
  output logic             memwb_r,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // The start cycle itself is one freeze cycle, and the counter then runs
  // down to zero inclusive, so it is loaded with MD_CYCLES-2.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic [7:0] md_cnt;
  logic [7:0] md_cnt_nxt;
  logic       load_use;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // State register for the mul/div wait FSM and its down-counter.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state logic. A memory wait state freezes the whole pipeline,
  // including the mul/div countdown, so nothing advances while mem_busy is
  // high. A start pulse seen while already waiting is ignored.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (!mem_busy) begin
      case (state)
        RUN: begin
          if (ex_md_start) begin
            state_nxt  = MD_WAIT;
            md_cnt_nxt = MD_LOAD;
          end
        end
        MD_WAIT: begin
          if (md_cnt == 8'd0) begin
            state_nxt = RUN;
          end else begin
            md_cnt_nxt = md_cnt - 8'd1;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // Output logic, in falling priority: reset, memory wait, mul/div occupancy,
  // taken branch, load-use. A clear wins over the enable inside the pipeline
  // register, so enables stay high wherever a clear is issued. The mul/div
  // case is checked before the branch so a start pulse always wins.
  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_r   = 1'b0;
    idex_en  = 1'b1;
    idex_r   = 1'b0;
    exmem_en = 1'b1;
    exmem_r  = 1'b0;
    memwb_en = 1'b1;
    memwb_r  = 1'b0;
    md_busy  = (state == MD_WAIT);
    if (r) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_r   = 1'b1;
      idex_en  = 1'b0;
      idex_r   = 1'b1;
      exmem_en = 1'b0;
      exmem_r  = 1'b1;
      memwb_en = 1'b0;
      memwb_r  = 1'b1;
      md_busy  = 1'b0;
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if ((state == MD_WAIT) || ex_md_start) begin
      // Hold IF/ID/EX and push a bubble into MEM behind the mul/div op.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exmem_r = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions; this also drops any
      // load-use hazard of the flushed ID instruction.
      ifid_r = 1'b1;
      idex_r = 1'b1;
    end else if (load_use) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_r  = 1'b1;
    end
  end

  // Stall-cycle counter, saturating at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Drives two hazard_ctrl instances (default parameters, and a narrow counter
//   with a shorter mul/div) from the same inputs and compares them against a
//   cycle-level reference model that tracks the remaining mul/div freeze cycles
//   and the expected stall count as plain integers.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       ex_md_start = 1'b0;
  logic       mem_busy = 1'b0;

  logic        pc_en0, ifid_en0, ifid_r0, idex_en0, idex_r0;
  logic        exmem_en0, exmem_r0, memwb_en0, memwb_r0, md_busy0;
  logic [31:0] stall0;
  logic        pc_en1, ifid_en1, ifid_r1, idex_en1, idex_r1;
  logic        exmem_en1, exmem_r1, memwb_en1, memwb_r1, md_busy1;
  logic [3:0]  stall1;

  logic [8:0]  ctlObs [2];
  logic        mdBusyObs [2];
  logic [31:0] stallObs [2];

  int     errors = 0;
  int     checks = 0;
  int     mdLeft [2];
  longint stallExp [2];
  int     mdCyc [2];
  longint cntMax [2];

  localparam logic [8:0] CTL_RESET   = 9'b001010101;
  localparam logic [8:0] CTL_DEFAULT = 9'b110101010;
  localparam logic [8:0] CTL_BUSY    = 9'b000000000;
  localparam logic [8:0] CTL_MD      = 9'b000001110;
  localparam logic [8:0] CTL_BRANCH  = 9'b111111010;
  localparam logic [8:0] CTL_LOADUSE = 9'b000111010;

  hazard_ctrl #(.MD_CYCLES(4), .REG_W(5), .CNT_W(32)) dut0 (
    .clk(clk), .r(r),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_busy(mem_busy),
    .pc_en(pc_en0), .ifid_en(ifid_en0), .ifid_r(ifid_r0),
    .idex_en(idex_en0), .idex_r(idex_r0),
    .exmem_en(exmem_en0), .exmem_r(exmem_r0),
    .memwb_en(memwb_en0), .memwb_r(memwb_r0),
    .md_busy(md_busy0), .stall_cycles(stall0)
  );

  hazard_ctrl #(.MD_CYCLES(3), .REG_W(5), .CNT_W(4)) dut1 (
    .clk(clk), .r(r),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_busy(mem_busy),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_r(ifid_r1),
    .idex_en(idex_en1), .idex_r(idex_r1),
    .exmem_en(exmem_en1), .exmem_r(exmem_r1),
    .memwb_en(memwb_en1), .memwb_r(memwb_r1),
    .md_busy(md_busy1), .stall_cycles(stall1)
  );

  assign ctlObs[0] = {pc_en0, ifid_en0, ifid_r0, idex_en0, idex_r0,
                      exmem_en0, exmem_r0, memwb_en0, memwb_r0};
  assign ctlObs[1] = {pc_en1, ifid_en1, ifid_r1, idex_en1, idex_r1,
                      exmem_en1, exmem_r1, memwb_en1, memwb_r1};
  assign mdBusyObs[0] = md_busy0;
  assign mdBusyObs[1] = md_busy1;
  assign stallObs[0]  = stall0;
  assign stallObs[1]  = {28'd0, stall1};

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control vector from the priority rules, given how many more
  // mul/div freeze cycles remain after this one.
  function automatic logic [8:0] expectCtl(int left, bit busy, bit start,
                                           bit br, bit lu);
    if (busy)                  return CTL_BUSY;
    if ((left > 0) || start)   return CTL_MD;
    if (br)                    return CTL_BRANCH;
    if (lu)                    return CTL_LOADUSE;
    return CTL_DEFAULT;
  endfunction

  task automatic applyStimulus(input bit busy, input bit start, input bit br,
                               input bit mread, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input bit u1, input bit u2);
    r               = 1'b0;
    mem_busy        = busy;
    ex_md_start     = start;
    ex_branch_taken = br;
    ex_mem_read     = mread;
    id_rs1          = rs1;
    id_rs2          = rs2;
    ex_rd           = rd;
    id_rs1_used     = u1;
    id_rs2_used     = u2;
  endtask

  // Compare both instances against the model for the current cycle, then
  // advance the model across the coming rising edge.
  task automatic checkCycle();
    bit lu;
    logic [8:0] exp;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    for (int k = 0; k < 2; k++) begin
      exp = expectCtl(mdLeft[k], mem_busy, ex_md_start, ex_branch_taken, lu);
      checkOutput($sformatf("ctl%0d", k), {23'd0, ctlObs[k]}, {23'd0, exp});
      checkOutput($sformatf("md_busy%0d", k), {31'd0, mdBusyObs[k]},
                  {31'd0, (mdLeft[k] > 0)});
      checkOutput($sformatf("stall%0d", k), stallObs[k], stallExp[k][31:0]);
      if (!exp[8] && (stallExp[k] < cntMax[k])) stallExp[k]++;
      if (!mem_busy) begin
        if (mdLeft[k] > 0)    mdLeft[k]--;
        else if (ex_md_start) mdLeft[k] = mdCyc[k] - 1;
      end
    end
  endtask

  task automatic stepCycle(input bit busy, input bit start, input bit br,
                           input bit mread, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input bit u1, input bit u2);
    @(negedge clk);
    applyStimulus(busy, start, br, mread, rs1, rs2, rd, u1, u2);
    #1;
    checkCycle();
  endtask

  task automatic idleCycle();
    stepCycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic checkReset(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, "_ctl"}, {23'd0, ctlObs[k]}, {23'd0, CTL_RESET});
      checkOutput({tag, "_md_busy"}, {31'd0, mdBusyObs[k]}, 32'd0);
      checkOutput({tag, "_stall"}, stallObs[k], 32'd0);
      mdLeft[k]   = 0;
      stallExp[k] = 0;
    end
  endtask

  initial begin
    int n;
    int mb;
    logic [31:0] s0;
    bit busy, start, br;

    mdCyc[0]  = 4;
    mdCyc[1]  = 3;
    cntMax[0] = 64'hFFFF_FFFF;
    cntMax[1] = 15;
    mdLeft[0] = 0;
    mdLeft[1] = 0;

    // Power-on reset held across two edges.
    repeat (2) @(posedge clk);
    #2;
    checkReset("por");
    idleCycle();
    checkOutput("release_ctl", {23'd0, ctlObs[0]}, {23'd0, CTL_DEFAULT});

    // Load-use on rs2, then the same pattern against x0.
    stepCycle(0, 0, 0, 1, 5'd7, 5'd5, 5'd5, 0, 1);
    checkOutput("lu_pc_en", {31'd0, pc_en0}, 32'd0);
    checkOutput("lu_idex_r", {31'd0, idex_r0}, 32'd1);
    stepCycle(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    checkOutput("lu_x0_pc_en", {31'd0, pc_en0}, 32'd1);

    // Branch coinciding with a load-use match: flush wins, no stall counted.
    s0 = stall0;
    stepCycle(0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 1, 0);
    checkOutput("br_lu_ctl", {23'd0, ctlObs[0]}, {23'd0, CTL_BRANCH});
    idleCycle();
    checkOutput("br_lu_stall", stall0 - s0, 32'd0);

    // Plain mul/div: four frozen cycles including the start cycle.
    s0 = stall0;
    stepCycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    n  = pc_en0 ? 0 : 1;
    mb = md_busy0 ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      idleCycle();
      if (pc_en0) break;
      n++;
      if (md_busy0) mb++;
    end
    checkOutput("md_freeze", n, 32'd4);
    checkOutput("md_busy_len", mb, 32'd3);
    checkOutput("md_stall_delta", stall0 - s0, 32'd4);

    // Mul/div with two memory wait cycles inside the wait window.
    stepCycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    n = pc_en0 ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      busy = (i == 1) || (i == 2);
      stepCycle(busy, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      if (busy) checkOutput("md_membusy_ctl", {23'd0, ctlObs[0]}, {23'd0, CTL_BUSY});
      if (pc_en0) break;
      n++;
    end
    checkOutput("md_busy_freeze", n, 32'd6);

    // Asynchronous reset in the middle of a mul/div wait.
    stepCycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idleCycle();
    #2;
    r = 1'b1;
    #1;
    checkReset("mid_md");
    @(posedge clk);
    #1;
    checkReset("held");
    idleCycle();
    checkOutput("post_reset_ctl", {23'd0, ctlObs[0]}, {23'd0, CTL_DEFAULT});

    // Twenty stalled cycles: the 4-bit counter must pin at 15.
    repeat (20) stepCycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idleCycle();
    checkOutput("sat_narrow", {28'd0, stall1}, 32'd15);
    checkOutput("sat_wide", stall0, 32'd20);

    // Randomized traffic, with branch and mul/div start kept exclusive.
    for (int i = 0; i < 1500; i++) begin
      busy  = ($urandom_range(0, 99) < 12);
      start = ($urandom_range(0, 99) < 8);
      br    = !start && ($urandom_range(0, 99) < 12);
      stepCycle(busy, start, br, ($urandom_range(0, 99) < 40),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("[TB] stimulus complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
